// File: rtl/almacen_lane_arbiter_pkg.sv
// Shared definitions for the single-lane arbiter: state codes, side IDs
// and default timing parameters.
`timescale 1ns/1ps
package almacen_lane_arbiter_pkg;

    localparam int ST_W = 2;

    // Lane state codes; these values are visible on the ST output.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    // Entry sides. These double as the round-robin memory of who went last.
    typedef enum logic [1:0] {
        SIDE1 = 2'd1,
        SIDE2 = 2'd2
    } side_t;

    localparam int GREEN_MIN_DEF = 8;
    localparam int GREEN_MAX_DEF = 32;
    localparam int CLEAR_T_DEF   = 4;
    localparam int DB_LEN_DEF    = 3;
    localparam int CW_DEF        = 6;

    // Grant state that a tie resolves to, given the side served last.
    function automatic state_t tie_grant(input side_t last_side);
        return (last_side == SIDE1) ? ST_GRANT2 : ST_GRANT1;
    endfunction

endpackage

// File: rtl/almacen_lane_arbiter_if.sv
// Sensor/light bundle between the lane arbiter and its surroundings.
// Request/grant semantics: Sx is a level request that stays high while a
// vehicle waits or passes; Vx high means side x may enter and is held for
// as long as the arbiter grants it; Rx is always the complement of Vx.
// At most one V is ever high. OCC high keeps the lane all-red.
`timescale 1ns/1ps
interface almacen_lane_arbiter_if;
    import almacen_lane_arbiter_pkg::*;

    logic            S1;
    logic            S2;
    logic            OCC;
    logic            V1;
    logic            R1;
    logic            V2;
    logic            R2;
    logic [ST_W-1:0] ST;

    modport master (
        output S1, S2, OCC,
        input  V1, R1, V2, R2, ST
    );

    modport slave (
        input  S1, S2, OCC,
        output V1, R1, V2, R2, ST
    );

endinterface

// File: rtl/almacen_lane_arbiter_sensor_cond.sv
// Sensor conditioning: 2-flop synchronizer, optionally followed by a
// stability filter when SENSOR_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module almacen_lane_arbiter_sensor_cond
    import almacen_lane_arbiter_pkg::*;
#(
    parameter int DB_LEN = DB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

`ifdef SENSOR_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic meta;
    logic sync;

    // Two-stage synchronizer for the asynchronous sensor line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    generate
        if (DB_ON && DB_LEN > 0) begin : g_db
            localparam int DBW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
            logic [DBW-1:0] cnt;
            logic           filt;

            // Accept a new level only after DB_LEN consecutive differing samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (sync == filt) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DB_LEN - 1)) begin
                    cnt  <= '0;
                    filt <= sync;
                end else begin
                    cnt <= cnt + DBW'(1);
                end
            end

            assign dout = filt;
        end else begin : g_raw
            assign dout = sync;
        end
    endgenerate

endmodule

// File: rtl/almacen_lane_arbiter.sv
// Single-lane arbiter: grants one entry side at a time with minimum and
// maximum green times, round-robin on ties, and an all-red clearance
// interval stretched by lane occupancy. Optional sensor debounce is
// enabled by defining SENSOR_DEBOUNCE_EN.
`timescale 1ns/1ps
module almacen_lane_arbiter
    import almacen_lane_arbiter_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int CLEAR_T   = CLEAR_T_DEF,
    parameter int DB_LEN    = DB_LEN_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    almacen_lane_arbiter_if.slave bus
);

    localparam logic [CW-1:0] T_GMIN = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] T_GMAX = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] T_CLR  = CW'(CLEAR_T - 1);

    logic s1q;
    logic s2q;
    logic occq;

    almacen_lane_arbiter_sensor_cond #(.DB_LEN(DB_LEN)) u_s1 (
        .clk (clk), .rst (rst), .din (bus.S1), .dout (s1q)
    );
    almacen_lane_arbiter_sensor_cond #(.DB_LEN(DB_LEN)) u_s2 (
        .clk (clk), .rst (rst), .din (bus.S2), .dout (s2q)
    );
    almacen_lane_arbiter_sensor_cond #(.DB_LEN(DB_LEN)) u_occ (
        .clk (clk), .rst (rst), .din (bus.OCC), .dout (occq)
    );

    state_t        state;
    state_t        state_nx;
    side_t         last;
    side_t         last_nx;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_nx;
    logic [CW-1:0] timer_inc;
    logic          leave1;
    logic          leave2;
    logic          v1_q;
    logic          r1_q;
    logic          v2_q;
    logic          r2_q;

    // The timer never wraps: it parks at GREEN_MAX-1, which also bounds CLEAR.
    assign timer_inc = (timer >= T_GMAX) ? timer : timer + CW'(1);

    // A green side yields once its minimum is served and it is either done or
    // contested; the GREEN_MAX term caps a contested green.
    assign leave1 = ((timer >= T_GMIN) && (!s1q || s2q)) || ((timer == T_GMAX) && s2q);
    assign leave2 = ((timer >= T_GMIN) && (!s2q || s1q)) || ((timer == T_GMAX) && s1q);

    // State, timer and round-robin memory registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            last  <= SIDE2;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            last  <= last_nx;
        end
    end

    // Next-state, timer and last-served decisions.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        last_nx  = last;
        case (state)
            ST_IDLE: begin
                timer_nx = '0;
                if (s1q && s2q) begin
                    state_nx = tie_grant(last);
                end else if (s1q) begin
                    state_nx = ST_GRANT1;
                end else if (s2q) begin
                    state_nx = ST_GRANT2;
                end
            end
            ST_GRANT1: begin
                if (leave1) begin
                    state_nx = ST_CLEAR;
                    last_nx  = SIDE1;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            ST_GRANT2: begin
                if (leave2) begin
                    state_nx = ST_CLEAR;
                    last_nx  = SIDE2;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            ST_CLEAR: begin
                if ((timer >= T_CLR) && !occq) begin
                    state_nx = ST_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer_inc;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // Lights are registered from the next state so they change with ST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            r1_q <= 1'b1;
            v2_q <= 1'b0;
            r2_q <= 1'b1;
        end else begin
            v1_q <= (state_nx == ST_GRANT1);
            r1_q <= (state_nx != ST_GRANT1);
            v2_q <= (state_nx == ST_GRANT2);
            r2_q <= (state_nx != ST_GRANT2);
        end
    end

    assign bus.V1 = v1_q;
    assign bus.R1 = r1_q;
    assign bus.V2 = v2_q;
    assign bus.R2 = r2_q;
    assign bus.ST = state;

endmodule

// File: tb/tb_almacen_lane_arbiter.sv
// Bench for almacen_lane_arbiter: directed scenarios plus random sensor
// traffic, all checked cycle by cycle against a behavioural lane model.
`timescale 1ns/1ps
module tb_almacen_lane_arbiter;
  import almacen_lane_arbiter_pkg::*;

  localparam int GREEN_MIN = 8;
  localparam int GREEN_MAX = 32;
  localparam int CLEAR_T   = 4;
  localparam int DB_LEN    = 3;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int LAT           = 3 + DB_LEN;
  localparam int GLITCH_GRANTS = 0;
`else
  localparam int LAT           = 3;
  localparam int GLITCH_GRANTS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #1 clk = ~clk;

  almacen_lane_arbiter_if bus ();

  almacen_lane_arbiter #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .CLEAR_T   (CLEAR_T),
    .DB_LEN    (DB_LEN),
    .CW        (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Phase uses the observable ST codes; age is cycles spent in the phase.
  int m_phase;
  int m_age;
  int m_last;
  bit h1[$];
  bit h2[$];
  bit ho[$];
  bit db1, db2, dbo;
  logic [5:0] exp_q[$];

  function automatic bit past(input bit h[$], input int d);
    if (h.size() > d) return h[h.size() - 1 - d];
    return 1'b0;
  endfunction

  // Level the arbiter acts on this edge, given raw input history.
  task automatic cond(input bit h[$], inout bit db, output bit seen);
`ifdef SENSOR_DEBOUNCE_EN
    bit flip;
    seen = db;
    flip = 1'b1;
    for (int i = 0; i < DB_LEN; i++) if (past(h, 2 + i) == db) flip = 1'b0;
    if (flip) db = ~db;
`else
    seen = past(h, 2);
`endif
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age = 0;
    m_last = 2;
    h1.delete();
    h2.delete();
    ho.delete();
    db1 = 1'b0;
    db2 = 1'b0;
    dbo = 1'b0;
  endtask

  task automatic model_step();
    bit a, b, o, mine, other, leave;
    int green_cycles;
    h1.push_back(bus.S1);
    h2.push_back(bus.S2);
    ho.push_back(bus.OCC);
    if (h1.size() > 16) begin
      void'(h1.pop_front());
      void'(h2.pop_front());
      void'(ho.pop_front());
    end
    cond(h1, db1, a);
    cond(h2, db2, b);
    cond(ho, dbo, o);
    case (m_phase)
      0: begin
        m_age = 0;
        if (a && b) m_phase = (m_last == 1) ? 2 : 1;
        else if (a) m_phase = 1;
        else if (b) m_phase = 2;
      end
      1, 2: begin
        mine = (m_phase == 1) ? a : b;
        other = (m_phase == 1) ? b : a;
        green_cycles = m_age + 1;
        leave = (green_cycles >= GREEN_MIN && (!mine || other)) ||
                (green_cycles >= GREEN_MAX && other);
        if (leave) begin
          m_last = m_phase;
          m_phase = 3;
          m_age = 0;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (m_age + 1 >= CLEAR_T && !o) begin
          m_phase = 0;
          m_age = 0;
        end else begin
          m_age++;
        end
      end
    endcase
  endtask

  // ---------------- driver / monitor ----------------
  // One clock: model advances on the edge, DUT checked on the falling edge.
  task automatic tick();
    logic [5:0] got, exp;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    exp_q.push_back({2'(m_phase), m_phase == 1, m_phase != 1, m_phase == 2, m_phase != 2});
    @(negedge clk);
    got = {bus.ST, bus.V1, bus.R1, bus.V2, bus.R2};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got {ST,V1,R1,V2,R2}=%b expected %b", $time, got, exp);
    end
    vectors++;
    if ((bus.V1 && bus.V2) || (bus.V1 && bus.R1) || (bus.V2 && bus.R2)) begin
      miscompares++;
      $display("FAIL light_invariant t=%0t V1=%b R1=%b V2=%b R2=%b required exclusive", $time,
               bus.V1, bus.R1, bus.V2, bus.R2);
    end
  endtask

  task automatic wait_st(input logic [1:0] st, input int budget, output int n);
    n = 0;
    while (bus.ST !== st && n < budget) begin
      tick();
      n++;
    end
    if (bus.ST !== st) n = -1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int vcnt;
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    bus.OCC = 1'b0;
    model_reset();
    #0.2 rst = 1'b1;
    #0.3;
    vectors++;
    if (bus.V1 !== 1'b0) begin miscompares++; $display("FAIL reset_v1 got %b expected 0", bus.V1); end
    vectors++;
    if (bus.V2 !== 1'b0) begin miscompares++; $display("FAIL reset_v2 got %b expected 0", bus.V2); end
    vectors++;
    if (bus.R1 !== 1'b1) begin miscompares++; $display("FAIL reset_r1 got %b expected 1", bus.R1); end
    vectors++;
    if (bus.R2 !== 1'b1) begin miscompares++; $display("FAIL reset_r2 got %b expected 1", bus.R2); end
    vectors++;
    if (bus.ST !== 2'd0) begin miscompares++; $display("FAIL reset_st got %0d expected 0", bus.ST); end
    tick();
    tick();
    rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      tick();
      if (bus.V1 || bus.V2 || bus.ST != 2'd0) vcnt++;
    end
    vectors++;
    if (vcnt != 0) begin miscompares++; $display("FAIL idle_quiet got %0d active cycles expected 0", vcnt); end
  endtask

  task automatic test_lone_request();
    int n, held, clr;
    bus.S1 = 1'b1;
    wait_st(2'd1, 20, n);
    vectors++;
    if (n != LAT) begin miscompares++; $display("FAIL lone_latency got %0d expected %0d", n, LAT); end
    held = 0;
    repeat (100) begin
      tick();
      if (bus.V1) held++;
    end
    vectors++;
    if (held != 100) begin miscompares++; $display("FAIL lone_hold got %0d expected 100", held); end
    bus.S1 = 1'b0;
    wait_st(2'd3, 20, n);
    clr = (n < 0) ? 0 : 1;
    while (bus.ST === 2'd3 && clr < 50) begin
      tick();
      if (bus.ST === 2'd3) clr++;
    end
    vectors++;
    if (clr != CLEAR_T) begin miscompares++; $display("FAIL lone_clear got %0d expected %0d", clr, CLEAR_T); end
    vectors++;
    if (bus.ST !== 2'd0) begin miscompares++; $display("FAIL lone_idle got %0d expected 0", bus.ST); end
  endtask

  task automatic test_contention();
    int n, v1len, clr;
    bus.S1 = 1'b1;
    wait_st(2'd1, 20, n);
    v1len = (n < 0) ? 0 : 1;
    tick();
    if (bus.V1) v1len++;
    bus.S2 = 1'b1;
    while (bus.V1 && v1len < 60) begin
      tick();
      if (bus.V1) v1len++;
    end
    vectors++;
    if (v1len != GREEN_MIN) begin miscompares++; $display("FAIL contend_green got %0d expected %0d", v1len, GREEN_MIN); end
    clr = 0;
    while (bus.ST === 2'd3 && clr < 50) begin
      clr++;
      tick();
    end
    vectors++;
    if (clr != CLEAR_T) begin miscompares++; $display("FAIL contend_clear got %0d expected %0d", clr, CLEAR_T); end
    wait_st(2'd2, 10, n);
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL contend_handover got %0d expected 1", n); end
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    wait_st(2'd3, 60, n);
    wait_st(2'd0, 60, n);
    vectors++;
    if (n < 0) begin miscompares++; $display("FAIL contend_settle got timeout expected idle"); end
  endtask

  task automatic test_tie();
    int n;
    pulse_reset();
    bus.S1 = 1'b1;
    bus.S2 = 1'b1;
    wait_st(2'd1, 20, n);
    vectors++;
    if (n != LAT) begin miscompares++; $display("FAIL tie_first got %0d expected %0d", n, LAT); end
    wait_st(2'd3, 60, n);
    wait_st(2'd2, 20, n);
    vectors++;
    if (n != CLEAR_T + 1) begin miscompares++; $display("FAIL tie_second got %0d expected %0d", n, CLEAR_T + 1); end
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    wait_st(2'd3, 60, n);
    wait_st(2'd0, 60, n);
    bus.S1 = 1'b1;
    bus.S2 = 1'b1;
    wait_st(2'd1, 20, n);
    vectors++;
    if (n != LAT) begin miscompares++; $display("FAIL tie_rr got %0d expected %0d", n, LAT); end
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    wait_st(2'd3, 60, n);
    wait_st(2'd0, 60, n);
  endtask

  task automatic test_glitch();
    int rises;
    logic prev;
    pulse_reset();
    bus.S1 = 1'b1;
    tick();
    tick();
    bus.S1 = 1'b0;
    rises = 0;
    prev = bus.V1;
    repeat (30) begin
      tick();
      if (bus.V1 && !prev) rises++;
      prev = bus.V1;
    end
    vectors++;
    if (rises != GLITCH_GRANTS) begin miscompares++; $display("FAIL glitch_grants got %0d expected %0d", rises, GLITCH_GRANTS); end
  endtask

  task automatic test_occ();
    int n, clr, vcnt;
    bus.S2 = 1'b1;
    wait_st(2'd2, 20, n);
    bus.S2 = 1'b0;
    wait_st(2'd3, 40, n);
    bus.OCC = 1'b1;
    clr = 0;
    vcnt = 0;
    repeat (20) begin
      tick();
      if (bus.ST === 2'd3) clr++;
      if (bus.V1 || bus.V2) vcnt++;
    end
    bus.OCC = 1'b0;
    while (bus.ST === 2'd3 && clr < 80) begin
      tick();
      if (bus.ST === 2'd3) clr++;
      if (bus.V1 || bus.V2) vcnt++;
    end
`ifndef SENSOR_DEBOUNCE_EN
    vectors++;
    if (clr != 22) begin miscompares++; $display("FAIL occ_hold got %0d expected 22", clr); end
`endif
    vectors++;
    if (vcnt != 0) begin miscompares++; $display("FAIL occ_green got %0d expected 0", vcnt); end
  endtask

  task automatic test_async_reset();
    int n;
    bus.S2 = 1'b1;
    wait_st(2'd2, 20, n);
    vectors++;
    if (n != LAT) begin miscompares++; $display("FAIL rst_grant got %0d expected %0d", n, LAT); end
    repeat (3) tick();
    #0.3 rst = 1'b1;
    #0.3;
    vectors++;
    if (bus.V2 !== 1'b0) begin miscompares++; $display("FAIL async_v2 got %b expected 0", bus.V2); end
    vectors++;
    if (bus.R2 !== 1'b1) begin miscompares++; $display("FAIL async_r2 got %b expected 1", bus.R2); end
    vectors++;
    if (bus.ST !== 2'd0) begin miscompares++; $display("FAIL async_st got %0d expected 0", bus.ST); end
    bus.S2 = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) bus.S1 = ~bus.S1;
      if ($urandom_range(0, 11) == 0) bus.S2 = ~bus.S2;
      if ($urandom_range(0, 29) == 0) bus.OCC = ~bus.OCC;
      tick();
    end
    bus.S1 = 1'b0;
    bus.S2 = 1'b0;
    bus.OCC = 1'b0;
    repeat (60) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lone_request();
    test_contention();
    test_tie();
    test_glitch();
    test_occ();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
